// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI byte engine.
package sd_spi_pkg;

  // Byte engine sequencing: wait, capture the next byte, shift it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2
  } spiState_t;

  localparam int DEFAULT_CLK_FREQ  = 100_000_000;
  localparam int DEFAULT_INIT_FREQ = 400_000;
  localparam int DEFAULT_WORK_FREQ = 10_000_000;

  // MOSI level while no byte is in flight (card sees all-ones filler).
  localparam logic       IDLE_MOSI = 1'b1;
  // InputData before any byte has been received.
  localparam logic [7:0] RESET_RX  = 8'hFF;

endpackage

// File: rtl/full_spi_if.sv
// Bus between the SD command FSM / SD card and the SPI byte engine.
interface full_spi_if;
  logic       SPI_Enable;
  logic       FastMode;
  logic [7:0] OutputData;
  logic       SPI_MISO;
  logic       SPI_MOSI;
  logic       SPI_CLK;
  logic [7:0] InputData;
  logic       DataClk;

  // The byte engine side.
  modport master (
    input  SPI_Enable, FastMode, OutputData, SPI_MISO,
    output SPI_MOSI, SPI_CLK, InputData, DataClk
  );

  // The controller and card side.
  modport slave (
    output SPI_Enable, FastMode, OutputData, SPI_MISO,
    input  SPI_MOSI, SPI_CLK, InputData, DataClk
  );
endinterface

// File: rtl/frequency_generator.sv
// Half-period tick generator for the SPI clock: one of two rates, chosen by sel.
module frequency_generator
  import sd_spi_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int FREQ_A   = DEFAULT_INIT_FREQ,
  parameter int FREQ_B   = DEFAULT_WORK_FREQ
) (
  input  logic MasterCLK,
  input  logic Reset,
  input  logic run,
  input  logic sel,
  output logic tick
);

  localparam int HALF_A   = CLK_FREQ / (2 * FREQ_A);
  localparam int HALF_B   = CLK_FREQ / (2 * FREQ_B);
  localparam int HALF_MAX = (HALF_A > HALF_B) ? HALF_A : HALF_B;
  localparam int CNT_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(HALF_A - 1);
  localparam logic [CNT_W-1:0] LAST_B = CNT_W'(HALF_B - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] lastCount;

  assign lastCount = sel ? LAST_B : LAST_A;
  assign tick      = run && (count == lastCount);

  // Count MasterCLK cycles within a half SPI period; parked at 0 while idle.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (!Reset) begin
      count <= '0;
    end else if (!run || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/full_spi.sv
// SPI mode-0 master byte engine, MSB first, with back-to-back byte streaming.
module full_spi
  import sd_spi_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int INIT_FREQ = DEFAULT_INIT_FREQ,
  parameter int WORK_FREQ = DEFAULT_WORK_FREQ
) (
  input  logic       MasterCLK,
  input  logic       Reset,
  full_spi_if.master spiBus
);

  spiState_t  state;
  logic       rateFast;   // rate latched at the byte load point
  logic       tick;
  logic [6:0] txShift;    // bits still to be sent, next one at [6]
  logic [6:0] rxShift;    // bits received so far in this byte
  logic [2:0] bitCount;
  logic       spiClk;
  logic       spiMosi;
  logic [7:0] inputData;
  logic       dataClk;

  frequency_generator #(
    .CLK_FREQ (CLK_FREQ),
    .FREQ_A   (INIT_FREQ),
    .FREQ_B   (WORK_FREQ)
  ) u_freq (
    .MasterCLK (MasterCLK),
    .Reset     (Reset),
    .run       (state != IDLE),
    .sel       (rateFast),
    .tick      (tick)
  );

  assign spiBus.SPI_CLK   = spiClk;
  assign spiBus.SPI_MOSI  = spiMosi;
  assign spiBus.InputData = inputData;
  assign spiBus.DataClk   = dataClk;

  // Byte sequencing, SPI clock/data generation and receive capture.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      rateFast  <= 1'b0;
      txShift   <= '0;
      rxShift   <= '0;
      bitCount  <= '0;
      spiClk    <= 1'b0;
      spiMosi   <= IDLE_MOSI;
      inputData <= RESET_RX;
      dataClk   <= 1'b0;
    end else begin
      dataClk <= 1'b0;
      case (state)
        IDLE: begin
          spiClk  <= 1'b0;
          spiMosi <= IDLE_MOSI;
          if (spiBus.SPI_Enable) state <= LOAD;
        end

        LOAD: begin
          txShift  <= spiBus.OutputData[6:0];
          spiMosi  <= spiBus.OutputData[7];
          bitCount <= '0;
          rateFast <= spiBus.FastMode;
          state    <= XFER;
        end

        XFER: begin
          if (tick) begin
            if (!spiClk) begin
              // Rising edge: the card's bit is stable, sample it.
              spiClk  <= 1'b1;
              rxShift <= {rxShift[5:0], spiBus.SPI_MISO};
              if (bitCount == 3'd7) begin
                inputData <= {rxShift, spiBus.SPI_MISO};
                dataClk   <= 1'b1;
              end
            end else begin
              spiClk <= 1'b0;
              if (bitCount == 3'd7) begin
                // Byte boundary: reload without a gap, or park.
                if (spiBus.SPI_Enable) begin
                  txShift  <= spiBus.OutputData[6:0];
                  spiMosi  <= spiBus.OutputData[7];
                  bitCount <= '0;
                  rateFast <= spiBus.FastMode;
                end else begin
                  spiMosi <= IDLE_MOSI;
                  state   <= IDLE;
                end
              end else begin
                // Falling edge: present the next bit for the card.
                spiMosi  <= txShift[6];
                txShift  <= {txShift[5:0], 1'b0};
                bitCount <= bitCount + 3'd1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_full_spi.sv
// Self-checking bench for full_spi: card model plus scoreboard queues.
module tb_full_spi;

  localparam int HALF_SLOW = 125;
  localparam int HALF_FAST = 5;
  localparam int SLOW_BYTE = 16 * HALF_SLOW;

  logic MasterCLK = 1'b0;
  logic Reset     = 1'b0;

  full_spi_if spiBus ();

  full_spi dut (
    .MasterCLK (MasterCLK),
    .Reset     (Reset),
    .spiBus    (spiBus)
  );

  always #5 MasterCLK = ~MasterCLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboards.
  logic [7:0] expRxQ[$];     // expected InputData per DataClk
  logic [7:0] expMosiQ[$];   // expected byte seen by the card on MOSI
  logic [7:0] cardQ[$];      // bytes the card returns after the current one
  int         dcTimes[$];    // cycle number of each DataClk

  // Card model: samples MOSI on rising SPI_CLK, shifts MISO on falling.
  logic [7:0] cardByte = 8'hFF;
  logic [7:0] cardRx   = 8'h00;
  int         cardBit  = 0;
  logic       misoReg  = 1'b1;

  assign spiBus.SPI_MISO = misoReg;

  always @(posedge spiBus.SPI_CLK) begin
    cardRx = {cardRx[6:0], spiBus.SPI_MOSI};
    cardBit++;
    if (cardBit == 8) begin
      if (expMosiQ.size() > 0) check("mosi_byte", cardRx, expMosiQ.pop_front());
      else check("mosi_queue_empty", expMosiQ.size(), 1);
    end
  end

  always @(negedge spiBus.SPI_CLK) begin
    if (cardBit == 8) begin
      cardBit  = 0;
      cardByte = (cardQ.size() > 0) ? cardQ.pop_front() : 8'hFF;
    end
    misoReg = cardByte[7 - cardBit];
  end

  task automatic cardPrime(input logic [7:0] b);
    cardBit  = 0;
    cardByte = b;
    misoReg  = b[7];
  endtask

  // Cycle counter and SPI_CLK phase / DataClk monitor.
  int cyc = 0;
  always @(posedge MasterCLK) cyc++;

  int   dcCount = 0, riseCount = 0;
  int   riseCyc, fallCyc;
  bit   validRise = 0, validFall = 0;
  int   minHigh, maxHigh, minLow, maxLow;
  logic lastClk = 1'b0;

  task automatic resetStats();
    validRise = 0; validFall = 0;
    minHigh = 1_000_000; maxHigh = 0;
    minLow  = 1_000_000; maxLow  = 0;
  endtask

  always @(negedge MasterCLK) begin
    if (spiBus.SPI_CLK && !lastClk) begin
      riseCount++;
      if (validFall) begin
        if (cyc - fallCyc < minLow) minLow = cyc - fallCyc;
        if (cyc - fallCyc > maxLow) maxLow = cyc - fallCyc;
      end
      riseCyc = cyc; validRise = 1;
    end
    if (!spiBus.SPI_CLK && lastClk) begin
      if (validRise) begin
        if (cyc - riseCyc < minHigh) minHigh = cyc - riseCyc;
        if (cyc - riseCyc > maxHigh) maxHigh = cyc - riseCyc;
      end
      fallCyc = cyc; validFall = 1;
    end
    lastClk = spiBus.SPI_CLK;
    if (spiBus.DataClk === 1'b1) begin
      dcCount++;
      dcTimes.push_back(cyc);
      if (expRxQ.size() > 0) check("rx_byte", spiBus.InputData, expRxQ.pop_front());
      else check("rx_queue_empty", expRxQ.size(), 1);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge MasterCLK);
  endtask

  task automatic waitDataClk(input string tag, input int budget);
    int startCount = dcCount;
    int n = 0;
    while (dcCount == startCount && n < budget) begin
      @(negedge MasterCLK);
      n++;
    end
    check({tag, "_dataclk_seen"}, (dcCount != startCount), 1);
  endtask

  task automatic waitRises(input string tag, input int target, input int budget);
    int n = 0;
    while (riseCount < target && n < budget) begin
      @(negedge MasterCLK);
      n++;
    end
    check({tag, "_rises_seen"}, (riseCount >= target), 1);
  endtask

  int dcBase, riseBase, dcIdx;

  initial begin
    spiBus.SPI_Enable = 1'b0;
    spiBus.FastMode   = 1'b0;
    spiBus.OutputData = 8'h00;
    resetStats();

    // Reset values, then a long idle stretch.
    #22;
    check("rst_spi_clk", spiBus.SPI_CLK, 1'b0);
    check("rst_mosi", spiBus.SPI_MOSI, 1'b1);
    check("rst_input_data", spiBus.InputData, 8'hFF);
    check("rst_dataclk", spiBus.DataClk, 1'b0);
    Reset = 1'b1;
    waitCycles(1000);
    check("idle_spi_clk", spiBus.SPI_CLK, 1'b0);
    check("idle_mosi", spiBus.SPI_MOSI, 1'b1);
    check("idle_input_data", spiBus.InputData, 8'hFF);
    check("idle_no_dataclk", dcCount, 0);

    // One slow byte: 0x40 out, card returns 0x01.
    cardPrime(8'h01);
    expMosiQ.push_back(8'h40);
    expRxQ.push_back(8'h01);
    resetStats();
    spiBus.FastMode   = 1'b0;
    spiBus.OutputData = 8'h40;
    spiBus.SPI_Enable = 1'b1;
    waitDataClk("slow", SLOW_BYTE + 100);
    spiBus.SPI_Enable = 1'b0;
    waitCycles(3 * HALF_SLOW);
    check("slow_dataclk_count", dcCount, 1);
    check("slow_input_data", spiBus.InputData, 8'h01);
    check("slow_high_min", minHigh, HALF_SLOW);
    check("slow_high_max", maxHigh, HALF_SLOW);
    check("slow_low_min", minLow, HALF_SLOW);
    check("slow_low_max", maxLow, HALF_SLOW);
    check("slow_end_mosi", spiBus.SPI_MOSI, 1'b1);
    check("slow_end_clk", spiBus.SPI_CLK, 1'b0);

    // Fast back-to-back stream: A5, 3C, FF echoed by the card.
    cardPrime(8'hA5);
    cardQ = '{8'h3C, 8'hFF};
    expMosiQ = '{8'hA5, 8'h3C, 8'hFF};
    expRxQ   = '{8'hA5, 8'h3C, 8'hFF};
    resetStats();
    dcIdx = dcTimes.size();
    spiBus.FastMode   = 1'b1;
    spiBus.OutputData = 8'hA5;
    spiBus.SPI_Enable = 1'b1;
    waitDataClk("fast0", 200);
    spiBus.OutputData = 8'h3C;
    waitDataClk("fast1", 200);
    spiBus.OutputData = 8'hFF;
    waitDataClk("fast2", 200);
    spiBus.SPI_Enable = 1'b0;
    waitCycles(40);
    check("fast_dataclk_count", dcCount, 4);
    check("fast_gap_1", dcTimes[dcIdx + 1] - dcTimes[dcIdx], 80);
    check("fast_gap_2", dcTimes[dcIdx + 2] - dcTimes[dcIdx + 1], 80);
    check("fast_high_min", minHigh, HALF_FAST);
    check("fast_high_max", maxHigh, HALF_FAST);
    check("fast_low_min", minLow, HALF_FAST);
    check("fast_low_max", maxLow, HALF_FAST);
    check("fast_end_mosi", spiBus.SPI_MOSI, 1'b1);

    // SPI_Enable dropped at bit 3: byte still completes.
    cardPrime(8'h5A);
    expMosiQ.push_back(8'h96);
    expRxQ.push_back(8'h5A);
    dcBase   = dcCount;
    riseBase = riseCount;
    spiBus.OutputData = 8'h96;
    spiBus.SPI_Enable = 1'b1;
    waitRises("drop", riseBase + 3, 200);
    spiBus.SPI_Enable = 1'b0;
    waitDataClk("drop", 200);
    waitCycles(60);
    check("drop_rises", riseCount - riseBase, 8);
    check("drop_dataclk", dcCount - dcBase, 1);
    check("drop_input_data", spiBus.InputData, 8'h5A);
    check("drop_idle_mosi", spiBus.SPI_MOSI, 1'b1);
    check("drop_idle_clk", spiBus.SPI_CLK, 1'b0);

    // FastMode toggled mid-byte: switch applies at the next byte.
    cardPrime(8'h81);
    cardQ = '{8'h7E};
    expMosiQ = '{8'h33, 8'hC3};
    expRxQ   = '{8'h81, 8'h7E};
    resetStats();
    riseBase = riseCount;
    spiBus.FastMode   = 1'b1;
    spiBus.OutputData = 8'h33;
    spiBus.SPI_Enable = 1'b1;
    waitRises("rate", riseBase + 2, 200);
    spiBus.FastMode = 1'b0;
    waitDataClk("rate0", 200);
    spiBus.OutputData = 8'hC3;
    check("rate_byte1_high_min", minHigh, HALF_FAST);
    check("rate_byte1_high_max", maxHigh, HALF_FAST);
    for (int n = 0; n < 20 && spiBus.SPI_CLK; n++) @(negedge MasterCLK);
    resetStats();
    waitDataClk("rate1", SLOW_BYTE + 100);
    spiBus.SPI_Enable = 1'b0;
    waitCycles(3 * HALF_SLOW);
    check("rate_byte2_high_min", minHigh, HALF_SLOW);
    check("rate_byte2_high_max", maxHigh, HALF_SLOW);
    check("rate_byte2_low_min", minLow, HALF_SLOW);
    check("rate_input_data", spiBus.InputData, 8'h7E);

    // Reset at bit 5 aborts the byte immediately.
    cardPrime(8'hE7);
    expMosiQ.delete();
    expRxQ.delete();
    dcBase   = dcCount;
    riseBase = riseCount;
    spiBus.OutputData = 8'h18;
    spiBus.SPI_Enable = 1'b1;
    waitRises("abort", riseBase + 5, SLOW_BYTE);
    waitCycles(50);
    #2 Reset = 1'b0;
    #1;
    check("abort_spi_clk", spiBus.SPI_CLK, 1'b0);
    check("abort_mosi", spiBus.SPI_MOSI, 1'b1);
    check("abort_input_data", spiBus.InputData, 8'hFF);
    check("abort_dataclk", spiBus.DataClk, 1'b0);
    spiBus.SPI_Enable = 1'b0;
    waitCycles(10);
    Reset = 1'b1;
    cardPrime(8'hFF);
    waitCycles(3 * HALF_SLOW);
    check("abort_no_dataclk", dcCount - dcBase, 0);
    check("abort_idle_clk", spiBus.SPI_CLK, 1'b0);
    check("abort_idle_mosi", spiBus.SPI_MOSI, 1'b1);
    check("abort_idle_input", spiBus.InputData, 8'hFF);
    check("left_exp_rx", expRxQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
